robo_mission_supervisor: RTL and testbench

Mission-level controller that sequences the collector-robot navigation FSM. It holds the robot in reset until commanded, releases it for a run, and monitors the robot's `forward`/`turn`/`remove` outputs. It counts collected trash and motion steps, and ends the mission on goal, abort, or a detected fault (spinning, step budget exhausted, stall). It sits between the operator/top-level command logic and the navigation FSM's reset input.

---
 rtl/robo_mission_supervisor.sv | 217 +++++++++++++++++++++
 tb/tb_robo_mission_supervisor.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/robo_mission_supervisor.sv
// robo_mission_supervisor
// Mission-level sequencer for the collector-robot navigation FSM. It holds
// the robot in reset until a mission is launched, then watches the robot's
// forward/turn/remove outputs. It ends the mission on goal, operator abort,
// spin, step budget exhaustion or stall.
// Optional build feature: define ROBO_SUP_ONEHOT_CHECK_EN to treat more than
// one simultaneous robot output as an illegal-combination fault (code 101).
module robo_mission_supervisor #(
    parameter int MAX_TRASH    = 10,
    parameter int MAX_STEPS    = 1000,
    parameter int MAX_SPIN     = 4,
    parameter int STALL_CYCLES = 8,
    parameter int TRASH_W      = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               fwd_in,
    input  logic               turn_in,
    input  logic               rem_in,
    output logic               robo_reset,
    output logic               busy,
    output logic               done,
    output logic               fault,
    output logic [2:0]         fault_code,
    output logic [TRASH_W-1:0] trash_count,
    output logic [15:0]        step_count
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam logic [2:0] CODE_NONE    = 3'b000;
    localparam logic [2:0] CODE_ABORT   = 3'b001;
    localparam logic [2:0] CODE_SPIN    = 3'b010;
    localparam logic [2:0] CODE_BUDGET  = 3'b011;
    localparam logic [2:0] CODE_STALL   = 3'b100;
    localparam logic [2:0] CODE_ILLEGAL = 3'b101;

    state_t             state_r;
    logic               robo_reset_r;
    logic               busy_r;
    logic               done_r;
    logic               fault_r;
    logic [2:0]         fault_code_r;
    logic [TRASH_W-1:0] trash_r;
    logic [15:0]        step_r;
    logic [15:0]        spin_r;
    logic [15:0]        stall_r;
    logic               rem_prev_r;

    logic               active_s;
    logic               illegal_s;
    logic [TRASH_W-1:0] trash_nxt_s;
    logic [15:0]        step_nxt_s;
    logic [15:0]        spin_nxt_s;
    logic [15:0]        stall_nxt_s;

    // Saturating increment for the 16-bit counters: never wraps to zero.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    // Post-update counter values for the current RUN cycle; exit decisions use these.
    always_comb begin
        active_s    = fwd_in | turn_in | rem_in;
`ifdef ROBO_SUP_ONEHOT_CHECK_EN
        illegal_s   = (fwd_in & turn_in) | (fwd_in & rem_in) | (turn_in & rem_in);
`else
        illegal_s   = 1'b0;
`endif
        trash_nxt_s = trash_r;
        step_nxt_s  = step_r;
        spin_nxt_s  = spin_r;
        stall_nxt_s = stall_r;
        if (illegal_s) begin
            // An illegal cycle leaves every counter untouched.
            trash_nxt_s = trash_r;
            step_nxt_s  = step_r;
            spin_nxt_s  = spin_r;
            stall_nxt_s = stall_r;
        end else begin
            if (active_s) begin
                step_nxt_s  = sat_inc16(step_r);
                stall_nxt_s = 16'd0;
            end else begin
                step_nxt_s  = step_r;
                stall_nxt_s = sat_inc16(stall_r);
            end
            if (rem_in && !rem_prev_r && (trash_r != {TRASH_W{1'b1}})) begin
                trash_nxt_s = trash_r + {{(TRASH_W-1){1'b0}}, 1'b1};
            end else begin
                trash_nxt_s = trash_r;
            end
            if (turn_in && !fwd_in) begin
                spin_nxt_s = sat_inc16(spin_r);
            end else begin
                spin_nxt_s = 16'd0;
            end
        end
    end

    // Mission FSM with registered outputs and counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            robo_reset_r <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            fault_r      <= 1'b0;
            fault_code_r <= CODE_NONE;
            trash_r      <= {TRASH_W{1'b0}};
            step_r       <= 16'd0;
            spin_r       <= 16'd0;
            stall_r      <= 16'd0;
            rem_prev_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE, ST_FAULT: begin
                    // Launch clears all mission state on entry so ARM shows zeros.
                    if (start) begin
                        state_r      <= ST_ARM;
                        robo_reset_r <= 1'b1;
                        busy_r       <= 1'b1;
                        done_r       <= 1'b0;
                        fault_r      <= 1'b0;
                        fault_code_r <= CODE_NONE;
                        trash_r      <= {TRASH_W{1'b0}};
                        step_r       <= 16'd0;
                        spin_r       <= 16'd0;
                        stall_r      <= 16'd0;
                        rem_prev_r   <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_ARM: begin
                    state_r      <= ST_RUN;
                    robo_reset_r <= 1'b0;
                    busy_r       <= 1'b1;
                end
                ST_RUN: begin
                    trash_r    <= trash_nxt_s;
                    step_r     <= step_nxt_s;
                    spin_r     <= spin_nxt_s;
                    stall_r    <= stall_nxt_s;
                    rem_prev_r <= rem_in;
                    if (abort) begin
                        state_r      <= ST_FAULT;
                        fault_code_r <= CODE_ABORT;
                        fault_r      <= 1'b1;
                        robo_reset_r <= 1'b1;
                        busy_r       <= 1'b0;
                    end else if (illegal_s) begin
                        state_r      <= ST_FAULT;
                        fault_code_r <= CODE_ILLEGAL;
                        fault_r      <= 1'b1;
                        robo_reset_r <= 1'b1;
                        busy_r       <= 1'b0;
                    end else if (trash_nxt_s == TRASH_W'(MAX_TRASH)) begin
                        state_r      <= ST_DONE;
                        done_r       <= 1'b1;
                        robo_reset_r <= 1'b1;
                        busy_r       <= 1'b0;
                    end else if (spin_nxt_s == 16'(MAX_SPIN)) begin
                        state_r      <= ST_FAULT;
                        fault_code_r <= CODE_SPIN;
                        fault_r      <= 1'b1;
                        robo_reset_r <= 1'b1;
                        busy_r       <= 1'b0;
                    end else if (step_nxt_s == 16'(MAX_STEPS)) begin
                        state_r      <= ST_FAULT;
                        fault_code_r <= CODE_BUDGET;
                        fault_r      <= 1'b1;
                        robo_reset_r <= 1'b1;
                        busy_r       <= 1'b0;
                    end else if (stall_nxt_s == 16'(STALL_CYCLES)) begin
                        state_r      <= ST_FAULT;
                        fault_code_r <= CODE_STALL;
                        fault_r      <= 1'b1;
                        robo_reset_r <= 1'b1;
                        busy_r       <= 1'b0;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    // Unreachable encoding: park safely with the robot held.
                    state_r      <= ST_IDLE;
                    robo_reset_r <= 1'b1;
                    busy_r       <= 1'b0;
                    done_r       <= 1'b0;
                    fault_r      <= 1'b0;
                end
            endcase
        end
    end

    assign robo_reset  = robo_reset_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign fault       = fault_r;
    assign fault_code  = fault_code_r;
    assign trash_count = trash_r;
    assign step_count  = step_r;

endmodule

// File: tb/tb_robo_mission_supervisor.sv
// Directed bench for robo_mission_supervisor: a vector table for the
// short scenarios plus hand-written sequences for goal/budget/abort runs.
module tb_robo_mission_supervisor;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        fwd_in = 1'b0;
    logic        turn_in = 1'b0;
    logic        rem_in = 1'b0;
    logic        robo_reset;
    logic        busy;
    logic        done;
    logic        fault;
    logic [2:0]  fault_code;
    logic [7:0]  trash_count;
    logic [15:0] step_count;

    int vec_cnt = 0;
    int miscompare_cnt = 0;

    // flags = {robo_reset, busy, done, fault}
    localparam logic [3:0] F_IDLE  = 4'b1000;
    localparam logic [3:0] F_ARM   = 4'b1100;
    localparam logic [3:0] F_RUN   = 4'b0100;
    localparam logic [3:0] F_DONE  = 4'b1010;
    localparam logic [3:0] F_FAULT = 4'b1001;

`ifdef ROBO_SUP_ONEHOT_CHECK_EN
    localparam logic REM_HOLD = 1'b0;
`else
    localparam logic REM_HOLD = 1'b1;
`endif

    typedef struct {
        logic        rst, st, ab, fw, tu, rm;
        logic [3:0]  flags;
        logic [2:0]  code;
        logic [7:0]  trash;
        logic [15:0] step;
    } vec_t;

    vec_t tbl[24];

    robo_mission_supervisor #(
        .MAX_TRASH(10), .MAX_STEPS(20), .MAX_SPIN(4), .STALL_CYCLES(8), .TRASH_W(8)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .fwd_in(fwd_in), .turn_in(turn_in), .rem_in(rem_in),
        .robo_reset(robo_reset), .busy(busy), .done(done), .fault(fault),
        .fault_code(fault_code), .trash_count(trash_count), .step_count(step_count)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(input logic r, s, a, f, t, m,
                                input logic [3:0] fl, input logic [2:0] c,
                                input logic [7:0] tr, input logic [15:0] sp);
        vec_t v;
        v.rst = r; v.st = s; v.ab = a; v.fw = f; v.tu = t; v.rm = m;
        v.flags = fl; v.code = c; v.trash = tr; v.step = sp;
        return v;
    endfunction

    task automatic apply(input logic r, s, a, f, t, m);
        @(negedge clock);
        reset = r; start = s; abort = a; fwd_in = f; turn_in = t; rem_in = m;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] fl, input logic [2:0] c,
                         input logic [7:0] tr, input logic [15:0] sp);
        logic [30:0] got;
        logic [30:0] want;
        got  = {robo_reset, busy, done, fault, fault_code, trash_count, step_count};
        want = {fl, c, tr, sp};
        vec_cnt++;
        if (got !== want) begin
            miscompare_cnt++;
            $display("FAIL %s: got rr/busy/done/fault=%b code=%b trash=%0d step=%0d, want %b code=%b trash=%0d step=%0d",
                     name, got[30:27], got[26:24], got[23:16], got[15:0],
                     fl, c, tr, sp);
        end
    endtask

    task automatic launch();
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // rst st ab fw tu rm | flags code trash step
        tbl[0]  = mk(1,0,0,0,0,0, F_IDLE,  3'b000, 8'd0, 16'd0);
        tbl[1]  = mk(0,0,1,0,0,0, F_IDLE,  3'b000, 8'd0, 16'd0);
        tbl[2]  = mk(0,1,0,0,0,0, F_ARM,   3'b000, 8'd0, 16'd0);
        tbl[3]  = mk(0,0,0,1,0,0, F_RUN,   3'b000, 8'd0, 16'd0);
        tbl[4]  = mk(0,0,0,0,1,0, F_RUN,   3'b000, 8'd0, 16'd1);
        tbl[5]  = mk(0,0,0,0,1,0, F_RUN,   3'b000, 8'd0, 16'd2);
        tbl[6]  = mk(0,1,0,0,1,0, F_RUN,   3'b000, 8'd0, 16'd3);
        tbl[7]  = mk(0,0,0,0,1,0, F_FAULT, 3'b010, 8'd0, 16'd4);
        tbl[8]  = mk(0,0,1,0,1,0, F_FAULT, 3'b010, 8'd0, 16'd4);
        tbl[9]  = mk(0,1,0,0,0,0, F_ARM,   3'b000, 8'd0, 16'd0);
        tbl[10] = mk(0,0,0,0,0,0, F_RUN,   3'b000, 8'd0, 16'd0);
        tbl[11] = mk(0,0,0,1,0,0, F_RUN,   3'b000, 8'd0, 16'd1);
        for (int i = 12; i < 19; i++) begin
            tbl[i] = mk(0,0,0,0,0,0, F_RUN, 3'b000, 8'd0, 16'd1);
        end
        tbl[19] = mk(0,0,0,0,0,0, F_FAULT, 3'b100, 8'd0, 16'd1);
        tbl[20] = mk(0,1,1,0,0,0, F_ARM,   3'b000, 8'd0, 16'd0);
        tbl[21] = mk(0,0,0,0,0,0, F_RUN,   3'b000, 8'd0, 16'd0);
`ifdef ROBO_SUP_ONEHOT_CHECK_EN
        tbl[22] = mk(0,0,0,1,0,1, F_FAULT, 3'b101, 8'd0, 16'd0);
`else
        tbl[22] = mk(0,0,0,1,0,1, F_RUN,   3'b000, 8'd1, 16'd1);
`endif
        tbl[23] = mk(1,1,0,0,0,0, F_IDLE,  3'b000, 8'd0, 16'd0);

        for (int i = 0; i < 24; i++) begin
            apply(tbl[i].rst, tbl[i].st, tbl[i].ab, tbl[i].fw, tbl[i].tu, tbl[i].rm);
            check($sformatf("tbl[%0d]", i), tbl[i].flags, tbl[i].code, tbl[i].trash, tbl[i].step);
        end

        // Goal: ten rising edges on rem_in separated by forward cycles.
        launch();
        check("goal_run", F_RUN, 3'b000, 8'd0, 16'd0);
        for (int i = 0; i < 9; i++) begin
            apply(0,0,0,0,0,1);
            apply(0,0,0,1,0,0);
        end
        check("goal_pre", F_RUN, 3'b000, 8'd9, 16'd18);
        apply(0,0,0,0,0,1);
        check("goal_done", F_DONE, 3'b000, 8'd10, 16'd19);
        apply(0,0,1,1,0,0);
        apply(0,0,0,0,0,1);
        check("done_frozen", F_DONE, 3'b000, 8'd10, 16'd19);
        apply(0,1,0,0,0,0);
        check("done_relaunch", F_ARM, 3'b000, 8'd0, 16'd0);

        // Goal and budget on the same edge: goal wins.
        launch();
        apply(0,0,0,1,0,0);
        for (int i = 0; i < 9; i++) begin
            apply(0,0,0,0,0,1);
            apply(0,0,0,1,0,0);
        end
        check("tie_pre", F_RUN, 3'b000, 8'd9, 16'd19);
        apply(0,0,0,0,0,1);
        check("tie_goal", F_DONE, 3'b000, 8'd10, 16'd20);

        // Step budget: rem rises once, then fwd/turn alternate with rem held.
        launch();
        apply(0,0,0,0,0,1);
        check("budget_first", F_RUN, 3'b000, 8'd1, 16'd1);
        for (int i = 0; i < 18; i++) begin
            apply(0,0,0, (i % 2 == 0) ? 1'b1 : 1'b0, (i % 2 == 1) ? 1'b1 : 1'b0, REM_HOLD);
        end
        check("budget_pre", F_RUN, 3'b000, 8'd1, 16'd19);
        apply(0,0,0,1,0,REM_HOLD);
        check("budget_fault", F_FAULT, 3'b011, 8'd1, 16'd20);

        // Abort on the same edge as the tenth removal.
        launch();
        for (int i = 0; i < 9; i++) begin
            apply(0,0,0,0,0,1);
            apply(0,0,0,1,0,0);
        end
        apply(0,0,1,0,0,1);
        check("abort_goal", F_FAULT, 3'b001, 8'd10, 16'd19);

        // Reset in the middle of a run.
        launch();
        apply(0,0,0,1,0,0);
        apply(0,0,0,0,0,1);
        check("mid_run", F_RUN, 3'b000, 8'd1, 16'd2);
        apply(1,0,0,1,0,0);
        check("mid_reset", F_IDLE, 3'b000, 8'd0, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
        $finish;
    end

endmodule
